// File: rtl/rv_fetch_predictor_if.sv
// Fetch-stage bus: hazard/EX controls and BTB training in, fetch PC and prediction out.
interface rv_fetch_predictor_if #(parameter int XLEN = 32);
  logic            pc_write_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            update_i;
  logic [XLEN-1:0] update_pc_i;
  logic [XLEN-1:0] update_target_i;
  logic            update_taken_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus_4_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            flush_o;
  logic [31:0]     mispredict_count_o;

  modport slave (
    input  pc_write_i, redirect_i, redirect_pc_i,
    input  update_i, update_pc_i, update_target_i, update_taken_i,
    output pc_o, pc_plus_4_o, pred_taken_o, pred_target_o, flush_o, mispredict_count_o
  );

  modport master (
    output pc_write_i, redirect_i, redirect_pc_i,
    output update_i, update_pc_i, update_target_i, update_taken_i,
    input  pc_o, pc_plus_4_o, pred_taken_o, pred_target_o, flush_o, mispredict_count_o
  );
endinterface

// File: rtl/rv_fetch_predictor.sv
// Fetch PC owner with a direct-mapped BTB (2-bit counters) predicting the next fetch address.
module rv_fetch_predictor #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset,
  rv_fetch_predictor_if.slave bus
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = XLEN - IDX - 2;

  typedef struct packed {
    logic            valid;
    logic [TW-1:0]   tag;
    logic [XLEN-1:0] tgt;
    logic [1:0]      ctr;
  } btb_ent_t;

  btb_ent_t        btb_q [BTB_ENTRIES];
  btb_ent_t        btb_d [BTB_ENTRIES];
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     cnt_q, cnt_d;

  logic [XLEN-1:0] pc_plus_4;
  logic [IDX-1:0]  lk_idx, up_idx;
  btb_ent_t        lk_ent, up_ent;
  logic            lk_hit, up_hit, pred_taken;
  logic [XLEN-1:0] pred_target;

  assign pc_plus_4   = pc_q + XLEN'(4);
  assign lk_idx      = pc_q[IDX+1:2];
  assign lk_ent      = btb_q[lk_idx];
  assign lk_hit      = lk_ent.valid && (lk_ent.tag == pc_q[XLEN-1:IDX+2]);
  assign pred_taken  = lk_hit && lk_ent.ctr[1];
  assign pred_target = pred_taken ? lk_ent.tgt : pc_plus_4;

  assign up_idx = bus.update_pc_i[IDX+1:2];
  assign up_ent = btb_q[up_idx];
  assign up_hit = up_ent.valid && (up_ent.tag == bus.update_pc_i[XLEN-1:IDX+2]);

  always_comb begin
    btb_d = btb_q;
    if (bus.update_i) begin
      if (up_hit) begin
        if (bus.update_taken_i) begin
          btb_d[up_idx].tgt = bus.update_target_i;
          if (up_ent.ctr != 2'b11) btb_d[up_idx].ctr = up_ent.ctr + 2'b01;
        end else if (up_ent.ctr != 2'b00) begin
          btb_d[up_idx].ctr = up_ent.ctr - 2'b01;
        end
      end else if (bus.update_taken_i) begin
        // Allocation evicts whatever lives at this index; start weakly taken.
        btb_d[up_idx].valid = 1'b1;
        btb_d[up_idx].tag   = bus.update_pc_i[XLEN-1:IDX+2];
        btb_d[up_idx].tgt   = bus.update_target_i;
        btb_d[up_idx].ctr   = 2'b10;
      end
    end
  end

  always_comb begin
    pc_d = pred_target;
    if (bus.redirect_i)       pc_d = bus.redirect_pc_i;
    else if (!bus.pc_write_i) pc_d = pc_q;
    cnt_d = cnt_q;
    if (bus.redirect_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, tgt: '0, ctr: 2'b01};
      end
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= btb_d[i];
    end
  end

  assign bus.pc_o               = pc_q;
  assign bus.pc_plus_4_o        = pc_plus_4;
  assign bus.pred_taken_o       = pred_taken;
  assign bus.pred_target_o      = pred_target;
  assign bus.flush_o            = bus.redirect_i;
  assign bus.mispredict_count_o = cnt_q;
endmodule

// File: tb/tb_rv_fetch_predictor.sv
// Randomized and directed checks of rv_fetch_predictor against a table-based reference model.
module tb_rv_fetch_predictor;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rv_fetch_predictor_if #(.XLEN(32)) bus ();
  rv_fetch_predictor #(.XLEN(32), .BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: entry keyed by full upper PC bits, counters as plain ints.
  bit        m_valid [N];
  bit [31:0] m_key   [N];
  bit [31:0] m_tgt   [N];
  int        m_ctr   [N];
  bit [31:0] m_pc;
  bit [31:0] m_cnt;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_key[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_pc = 0; m_cnt = 0;
  endfunction

  function automatic void m_lookup(input bit [31:0] pc, output bit t, output bit [31:0] tg);
    int i;
    i  = (pc / 4) % N;
    t  = m_valid[i] && (m_key[i] == pc / (4 * N)) && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_edge();
    bit t; bit [31:0] tg; int i; bit hit;
    m_lookup(m_pc, t, tg);
    if (bus.update_i) begin
      i   = (bus.update_pc_i / 4) % N;
      hit = m_valid[i] && (m_key[i] == bus.update_pc_i / (4 * N));
      if (hit) begin
        if (bus.update_taken_i) begin
          m_tgt[i] = bus.update_target_i;
          if (m_ctr[i] < 3) m_ctr[i]++;
        end else if (m_ctr[i] > 0) m_ctr[i]--;
      end else if (bus.update_taken_i) begin
        m_valid[i] = 1; m_key[i] = bus.update_pc_i / (4 * N);
        m_tgt[i] = bus.update_target_i; m_ctr[i] = 2;
      end
    end
    if (bus.redirect_i) begin
      m_pc = bus.redirect_pc_i;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end else if (bus.pc_write_i) m_pc = tg;
  endfunction

  task automatic idle();
    bus.pc_write_i = 1; bus.redirect_i = 0; bus.redirect_pc_i = 0;
    bus.update_i = 0; bus.update_pc_i = 0; bus.update_target_i = 0; bus.update_taken_i = 0;
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect_to(input bit [31:0] pc);
    idle(); bus.redirect_i = 1; bus.redirect_pc_i = pc; tick(); idle();
  endtask

  task automatic train(input bit [31:0] pc, input bit [31:0] tg, input bit tk);
    idle(); bus.update_i = 1; bus.update_pc_i = pc; bus.update_target_i = tg;
    bus.update_taken_i = tk; bus.pc_write_i = 0; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); m_reset();
    @(negedge clk); #1;
    total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h exp %h", bus.pc_o, 32'h0); end
    total++; if (bus.pc_plus_4_o !== 32'h4) begin bad++; $display("FAIL reset_pc4: got %h exp %h", bus.pc_plus_4_o, 32'h4); end
    total++; if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h4) begin bad++; $display("FAIL reset_pred: got %b/%h exp 0/00000004", bus.pred_taken_o, bus.pred_target_o); end
    total++; if (bus.mispredict_count_o !== 32'h0) begin bad++; $display("FAIL reset_cnt: got %0d exp 0", bus.mispredict_count_o); end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_sequential();
    bit [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (bus.pc_o !== exp_pc[k] || bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL seq_pc%0d: got %h/%b exp %h/0", k, bus.pc_o, bus.pred_taken_o, exp_pc[k]); end
      tick();
    end
  endtask

  task automatic test_alloc();
    train(32'h10, 32'h40, 1);
    redirect_to(32'h10); #1;
    total++; if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h40) begin bad++; $display("FAIL alloc_pred: got %b/%h exp 1/00000040", bus.pred_taken_o, bus.pred_target_o); end
    tick(); #1;
    total++; if (bus.pc_o !== 32'h40) begin bad++; $display("FAIL alloc_next: got %h exp %h", bus.pc_o, 32'h40); end
  endtask

  task automatic test_train_not_taken();
    train(32'h10, 32'h0, 0);
    train(32'h10, 32'h0, 0);
    redirect_to(32'h10); #1;
    total++; if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h14) begin bad++; $display("FAIL nt_pred: got %b/%h exp 0/00000014", bus.pred_taken_o, bus.pred_target_o); end
    tick(); #1;
    total++; if (bus.pc_o !== 32'h14) begin bad++; $display("FAIL nt_next: got %h exp %h", bus.pc_o, 32'h14); end
  endtask

  task automatic test_stall_redirect();
    bit [31:0] c0;
    redirect_to(32'h20);
    c0 = m_cnt;
    bus.pc_write_i = 0; #1;
    total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL stall_noflush: got %b exp 0", bus.flush_o); end
    tick();
    bus.pc_write_i = 0; #1;
    total++; if (bus.pc_o !== 32'h20) begin bad++; $display("FAIL stall_hold: got %h exp %h", bus.pc_o, 32'h20); end
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h80; #1;
    total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL stall_flush: got %b exp 1", bus.flush_o); end
    tick(); idle(); bus.pc_write_i = 0; #1;
    total++; if (bus.pc_o !== 32'h80) begin bad++; $display("FAIL stall_redir: got %h exp %h", bus.pc_o, 32'h80); end
    total++; if (bus.mispredict_count_o !== c0 + 1) begin bad++; $display("FAIL stall_cnt: got %0d exp %0d", bus.mispredict_count_o, c0 + 1); end
    tick(); #1;
    total++; if (bus.pc_o !== 32'h80) begin bad++; $display("FAIL stall_hold2: got %h exp %h", bus.pc_o, 32'h80); end
    idle();
  endtask

  task automatic test_alias();
    train(32'h10, 32'h40, 1);
    train(32'h50, 32'h90, 1);
    redirect_to(32'h50); #1;
    total++; if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h90) begin bad++; $display("FAIL alias_hit: got %b/%h exp 1/00000090", bus.pred_taken_o, bus.pred_target_o); end
    redirect_to(32'h10); #1;
    total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL alias_miss: got %b exp 0", bus.pred_taken_o); end
    tick(); #1;
    total++; if (bus.pc_o !== 32'h14) begin bad++; $display("FAIL alias_next: got %h exp %h", bus.pc_o, 32'h14); end
  endtask

  task automatic test_back_to_back();
    // Training the entry being fetched must not bypass into this cycle's lookup.
    redirect_to(32'h200); #1;
    bus.update_i = 1; bus.update_pc_i = 32'h200; bus.update_target_i = 32'h300; bus.update_taken_i = 1; #1;
    total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL b2b_nobypass: got %b exp 0", bus.pred_taken_o); end
    tick(); idle(); #1;
    total++; if (bus.pc_o !== 32'h204) begin bad++; $display("FAIL b2b_next: got %h exp %h", bus.pc_o, 32'h204); end
  endtask

  task automatic test_random();
    bit [31:0] pool [6] = '{32'h10, 32'h50, 32'h20, 32'h100, 32'h104, 32'h140};
    bit t; bit [31:0] tg;
    for (int k = 0; k < 400; k++) begin
      idle();
      bus.pc_write_i = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 4) == 0) begin
        bus.redirect_i = 1;
        bus.redirect_pc_i = pool[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 1) == 0) begin
        bus.update_i = 1;
        bus.update_pc_i = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
        bus.update_target_i = pool[$urandom_range(0, 5)];
        bus.update_taken_i = $urandom_range(0, 2) != 0;
      end
      #1;
      m_lookup(m_pc, t, tg);
      total++;
      if (bus.pc_o !== m_pc || bus.pc_plus_4_o !== m_pc + 32'd4 || bus.pred_taken_o !== t ||
          bus.pred_target_o !== tg || bus.flush_o !== bus.redirect_i || bus.mispredict_count_o !== m_cnt) begin
        bad++;
        $display("FAIL rand_%0d: got pc=%h p4=%h pt=%b tg=%h fl=%b cnt=%0d exp pc=%h pt=%b tg=%h cnt=%0d",
                 k, bus.pc_o, bus.pc_plus_4_o, bus.pred_taken_o, bus.pred_target_o, bus.flush_o,
                 bus.mispredict_count_o, m_pc, t, tg, m_cnt);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    train(32'h10, 32'h40, 1);
    redirect_to(32'h1000);
    #2 reset = 0; #1;
    m_reset();
    total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL rstmid_pc: got %h exp %h", bus.pc_o, 32'h0); end
    total++; if (bus.mispredict_count_o !== 32'h0 || bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h4) begin bad++; $display("FAIL rstmid_state: got cnt=%0d pt=%b tg=%h exp 0/0/00000004", bus.mispredict_count_o, bus.pred_taken_o, bus.pred_target_o); end
    @(negedge clk); reset = 1;
    redirect_to(32'h10); #1;
    total++; if (bus.pc_o !== 32'h10 || bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL rstmid_btb: got %h/%b exp 00000010/0", bus.pc_o, bus.pred_taken_o); end
    total++; if (bus.mispredict_count_o !== 32'h1) begin bad++; $display("FAIL rstmid_cnt: got %0d exp 1", bus.mispredict_count_o); end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFC); #1;
    total++; if (bus.pc_plus_4_o !== 32'h0 || bus.pred_target_o !== 32'h0) begin bad++; $display("FAIL wrap_p4: got %h/%h exp 0/0", bus.pc_plus_4_o, bus.pred_target_o); end
    tick(); #1;
    total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL wrap_next: got %h exp %h", bus.pc_o, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_alloc();
    test_train_not_taken();
    test_stall_redirect();
    test_alias();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
